// File: rtl/pool_stream_ctrl_pkg.sv
// pool_stream_ctrl_pkg: shared widths, FSM state encoding and tag type for the pooling control stage
package pool_stream_ctrl_pkg;

    localparam int WID_PE_BITS = 16;
    localparam int ADDR_FIFO   = 10;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        FLUSH,
        DONE
    } state_t;

    typedef struct packed {
        logic last;
        logic valid;
    } tag_t;

endpackage

// File: rtl/pool_tag_delay.sv
// pool_tag_delay: fixed-depth shift line carrying {last, valid} tags in step with the pooling pipeline
module pool_tag_delay
    import pool_stream_ctrl_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t [DEPTH-1:0] line;

    // Advance one stage per enabled cycle; clear drops every pending tag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line <= '0;
        end else if (clr) begin
            line <= '0;
        end else if (en) begin
            line[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) line[i] <= line[i-1];
        end
    end

    assign tag_out = line[DEPTH-1];

endmodule

// File: rtl/pool_stream_ctrl.sv
// pool_stream_ctrl: drives the pooling datapath and tags its 2x2/stride-2 results; optional POOL_OUT_ADDR_EN adds an output address counter
module pool_stream_ctrl
    import pool_stream_ctrl_pkg::*;
#(
    parameter int DATA_W   = WID_PE_BITS,
    parameter int ADDR_W   = ADDR_FIFO,
    parameter int POOL_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] row_length,
    input  logic [ADDR_W-1:0] num_rows,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [DATA_W-1:0] pl_data,
    output logic              pl_shift,
    output logic              pl_lb_reset,
    output logic              pl_enable,
    output logic [ADDR_W-1:0] pl_row_length,
    input  logic [DATA_W-1:0] pl_result,
`ifdef POOL_OUT_ADDR_EN
    input  logic [ADDR_W-1:0] out_base,
    output logic [ADDR_W-1:0] out_addr,
`endif
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int FW = (POOL_LAT > 1) ? $clog2(POOL_LAT) : 1;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] num_rows_q;
    logic [ADDR_W-1:0] col_cnt;
    logic [ADDR_W-1:0] row_cnt;
    logic [FW-1:0]     fl_cnt;
    logic              accept;
    logic              col_end;
    logic              row_end;
    logic              empty;
    tag_t              tag_in;
    tag_t              tag_out;

    assign accept   = in_valid & in_ready;
    assign col_end  = col_cnt == pl_row_length - ADDR_W'(1);
    assign row_end  = row_cnt == num_rows_q - ADDR_W'(1);
    assign empty    = pl_row_length == '0 || num_rows_q == '0;
    assign pl_shift = accept;
    assign pl_data  = in_ready ? in_data : '0;

    // Next-state decode; DONE falls back to IDLE through the default arm
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? CLEAR : IDLE;
            CLEAR:   state_nx = empty ? FLUSH : RUN;
            RUN:     state_nx = (accept && col_end && row_end) ? FLUSH : RUN;
            FLUSH:   state_nx = (fl_cnt == FW'(POOL_LAT - 1)) ? DONE : FLUSH;
            default: state_nx = IDLE;
        endcase
    end

    // Frame FSM with outputs registered from the next state; sizes latched on an accepted start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            in_ready      <= 1'b0;
            pl_enable     <= 1'b0;
            pl_lb_reset   <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            fl_cnt        <= '0;
            pl_row_length <= '0;
            num_rows_q    <= '0;
        end else begin
            state       <= state_nx;
            in_ready    <= state_nx == RUN;
            pl_enable   <= state_nx == RUN || state_nx == FLUSH;
            pl_lb_reset <= state_nx == CLEAR;
            busy        <= state_nx != IDLE;
            done        <= state_nx == DONE;
            fl_cnt      <= (state == FLUSH) ? fl_cnt + FW'(1) : '0;
            if (state == IDLE && start) begin
                pl_row_length <= row_length;
                num_rows_q    <= num_rows;
            end
        end
    end

    // Pixel position of the next accept, restarted for every frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (state == CLEAR) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (accept) begin
            col_cnt <= col_end ? '0 : col_cnt + ADDR_W'(1);
            row_cnt <= row_cnt + ADDR_W'(col_end);
        end
    end

    // An odd row/odd column pixel closes a window; odd trailing rows/columns never reach that position
    assign tag_in.valid = accept & row_cnt[0] & col_cnt[0];
    assign tag_in.last  = tag_in.valid
                        && row_cnt == {num_rows_q[ADDR_W-1:1], 1'b0} - ADDR_W'(1)
                        && col_cnt == {pl_row_length[ADDR_W-1:1], 1'b0} - ADDR_W'(1);

    pool_tag_delay #(
        .DEPTH(POOL_LAT)
    ) u_tag_delay (
        .clk    (clk),
        .rst    (rst),
        .clr    (state == IDLE || state == CLEAR),
        .en     (state == RUN || state == FLUSH),
        .tag_in (tag_in),
        .tag_out(tag_out)
    );

    assign out_valid = tag_out.valid;
    assign out_last  = tag_out.last;
    assign out_data  = out_valid ? pl_result : '0;

`ifdef POOL_OUT_ADDR_EN
    // Output address: loaded at frame start, stepped after every emitted result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_addr <= '0;
        end else if (state == IDLE && start) begin
            out_addr <= out_base;
        end else if (out_valid) begin
            out_addr <= out_addr + ADDR_W'(1);
        end
    end
`endif

endmodule

// File: doc/pool_stream_ctrl.md
# pool_stream_ctrl

Control and output-tagging stage wrapped around the `pooling` datapath. It accepts the raw activation stream from the PE array, drives `pooling`'s `in_pool_data`, `shifting_line`, `line_buffer_reset`, `pool_enable` and `row_length`, and marks which `out_pool_data` samples are real 2x2/stride-2 results. It emits those results as a valid-tagged stream with a last marker to the next stage, the output buffer writer.

## Interface
- `DATA_W`, default `` `WID_PE_BITS ``: pixel width.
- `ADDR_W`, default `` `ADDR_FIFO ``: width of the row/column counters and the size inputs.
- `POOL_LAT`, default 3: cycles from the accept edge of a pixel to the `pooling` output register holding the window completed by that pixel.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: one-cycle pulse that begins a frame.
- `row_length` in ADDR_W: columns per row. Sampled at `start`.
- `num_rows` in ADDR_W: rows per frame. Sampled at `start`.
- `in_valid` in 1: upstream pixel valid.
- `in_data` in DATA_W: upstream pixel.
- `in_ready` out 1: pixel accepted when `in_valid && in_ready`.
- `pl_data` out DATA_W: to `pooling.in_pool_data`.
- `pl_shift` out 1: to `shifting_line`.
- `pl_lb_reset` out 1: to `line_buffer_reset`.
- `pl_enable` out 1: to `pool_enable`.
- `pl_row_length` out ADDR_W: to `pooling.row_length`.
- `pl_result` in DATA_W: from `out_pool_data`.
- `out_valid` out 1: pooled result valid.
- `out_data` out DATA_W: pooled result.
- `out_last` out 1: final result of the frame.
- `busy` out 1: state is not IDLE.
- `done` out 1: one-cycle pulse at end of frame.

## Operation
- **FSM states:**
  - IDLE → CLEAR when `start` is high. Size inputs are latched on that cycle.
  - CLEAR lasts 1 cycle with `pl_lb_reset`=1, then goes to RUN.
  - RUN → FLUSH on the accept of pixel (`num_rows`-1, `row_length`-1).
  - FLUSH lasts POOL_LAT cycles, then goes to DONE.
  - DONE lasts 1 cycle with `done`=1, then goes to IDLE.
- **In RUN:**
  - `in_ready`=1.
  - `pl_shift` = `in_valid`, combinational.
  - `pl_data` = `in_data`.
- **Enable and passthrough:**
  - `pl_enable`=1 in RUN and FLUSH, 0 otherwise.
  - `pl_row_length` = latched `row_length`.
- **Counters:**
  - `col_cnt` advances on each accept and wraps at `row_length`-1.
  - On wrap, `row_cnt` increments.
- **Window tag:**
  - Asserted on the accept of a pixel with `row_cnt[0]`=1 and `col_cnt[0]`=1, restricted to pixels where the full 2x2 window lies inside the frame.
  - Odd trailing rows and columns are dropped.
- **Tag delay:**
  - The tag enters a POOL_LAT-deep shift register that advances every cycle in RUN and FLUSH, and is cleared in IDLE and CLEAR.
  - Its output drives `out_valid`, and `out_data` = `pl_result`.
- **Last marker:** `out_last` accompanies the tag of the window ending at row 2·floor(`num_rows`/2)-1, column 2·floor(`row_length`/2)-1.
- **Result count:** exactly floor(R/2)·floor(C/2) `out_valid` pulses per frame.
- **Degenerate sizes:**
  - If R<2 or C<2, the frame still consumes R·C pixels and produces zero results and no `out_last`. `done` still pulses.
  - If R=0 or C=0, the FSM goes from CLEAR directly to FLUSH.
- **`start` outside IDLE:** ignored.
- **`in_valid` outside RUN:** ignored, since `in_ready`=0.
- **Reset (asynchronous, including mid-frame):**
  - All outputs return to 0, the FSM returns to IDLE, and counters and the tag line clear.
  - The partially processed frame is discarded.
  - `pl_lb_reset` is reasserted by the next CLEAR.

## Timing
- **Reset values:** all outputs 0.
- **Start:** `start` at edge 0 → CLEAR during cycle 1 → RUN (`in_ready`=1) from cycle 2.
- **Latency:**
  - The accept edge of a window-completing pixel is cycle t.
  - `out_valid` is high in cycle t+POOL_LAT, for exactly 1 cycle.
- **Bubbles:** a cycle with `in_valid`=0 in RUN does not shift and does not tag. Pending tags still drain.
- **Completion:**
  - The last accept happens at edge T.
  - FLUSH covers cycles T+1 through T+POOL_LAT.
  - `done` is high in cycle T+POOL_LAT+1.
  - `out_last` is never later than the final FLUSH cycle.
- **Back-to-back frames:** `start` is accepted in the cycle after DONE.

## Configuration
- **`POOL_OUT_ADDR_EN` defined:**
  - Adds input `out_base` (ADDR_W) and output `out_addr` (ADDR_W).
  - `out_addr` loads `out_base` at `start` and increments after each `out_valid`.
  - It wraps modulo 2^ADDR_W.
  - `out_addr` is valid alongside `out_valid`.
  - `out_addr` resets to 0.
- **Not defined:** neither port exists and no address logic is generated.

## Structure
- **Shared constants:**
  - FSM state encodings (IDLE, CLEAR, RUN, FLUSH, DONE) go in `header.vh`.
  - Width macros come from `header.vh`.
- **Sub-module `pool_tag_delay`:**
  - Parameterized by depth POOL_LAT.
  - Carries {last, valid}.
  - Has a synchronous clear and a shift enable.

## Test plan
- **4x4 frame, continuous `in_valid`, pixel values 0..15:** 4 `out_valid` pulses with `out_data` 5, 7, 13, 15; `out_last` on 15; `done` POOL_LAT+1 cycles after the last accept.
- **5x3 frame (C=5, R=3):** 15 pixels consumed, 2 results (windows ending at col 1 and col 3 of row 1); trailing row and column dropped.
- **4x4 frame with `in_valid` toggling 1,0 every cycle:** same 4 results; each result appears exactly POOL_LAT cycles after its own accept.
- **`rst` asserted midway through row 2 of a 4x4 frame:** all outputs 0 immediately, no `done`; a new frame with signed values -8..7 yields -3, -1, 5, 7.
- **`start` pulsed during RUN, and `in_valid` high in IDLE:** no effect; result count unchanged.
- **`POOL_OUT_ADDR_EN` with `out_base`=0x3FE, ADDR_W=10, 4x4 frame:** `out_addr` 0x3FE, 0x3FF, 0x000, 0x001.
